// File: rtl/kernel_cra_pkg.sv
// -----------------------------------------------------------------------------
// kernel_cra_pkg
// Shared definitions for the kernel CRA responder:
//   - register word indices (decoded from address[5:3])
//   - CTRL / STATUS bit positions
//   - kernel control FSM state enum
//   - byte_merge(): byte-enable write merge for RW registers
// -----------------------------------------------------------------------------
package kernel_cra_pkg;

   localparam logic [2:0] REG_ID      = 3'd0;
   localparam logic [2:0] REG_CTRL    = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_ARG0    = 3'd3;
   localparam logic [2:0] REG_ARG1    = 3'd4;
   localparam logic [2:0] REG_CYCLES  = 3'd5;
   localparam logic [2:0] REG_SCRATCH = 3'd6;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;
   localparam int STATUS_IRQ_BIT  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Replace only the bytes of old_val whose byteenable bit is set.
   function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  be);
      logic [63:0] merged;
      merged = old_val;
      for (int i = 0; i < 8; i++) begin
         if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/kernel_cra_cycle_counter.sv
// -----------------------------------------------------------------------------
// kernel_cra_cycle_counter
// 64-bit saturating cycle counter for the kernel RUN interval.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset (count -> 0)
//   clear   : load 0 (takes priority over enable)
//   enable  : add 1 per cycle, sticking at all ones
//   count   : current count
// -----------------------------------------------------------------------------
module kernel_cra_cycle_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        enable,
   output logic [63:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 64'd1;
      end
   end

endmodule

// File: rtl/kernel_cra_responder.sv
// -----------------------------------------------------------------------------
// kernel_cra_responder
// Avalon-style CRA slave that launches a kernel and reports its completion.
//
// Parameters:
//   CRA_ID  : value returned by the ID register
//   ADDR_W  : CRA byte-address width (only address[5:3] is decoded)
// Ports:
//   kernel_clk                  : sole clock, rising edge
//   board_kernel_reset_reset_n  : synchronous active-low reset
//   address/read/write/writedata/byteenable/burstcount/debugaccess : CRA slave in
//   waitrequest/readdata/readdatavalid                             : CRA slave out
//   kernel_start                : one-cycle launch pulse
//   kernel_arg0/kernel_arg1     : live copies of ARG0/ARG1
//   kernel_done                 : completion pulse from the kernel
//   kernel_irq                  : level interrupt, DONE & IRQ_EN
//
// Build option: define KERNEL_CRA_CYCLE_COUNTER_EN to include the RUN-cycle
// counter behind the CYCLES register; otherwise CYCLES reads 0.
// -----------------------------------------------------------------------------
module kernel_cra_responder
   import kernel_cra_pkg::*;
#(
   parameter logic [63:0] CRA_ID = 64'h0000_4B52_4E4C_0001,
   parameter int          ADDR_W = 30
) (
   input  logic              kernel_clk,
   input  logic              board_kernel_reset_reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [63:0]       writedata,
   input  logic [7:0]        byteenable,
   input  logic              burstcount,
   input  logic              debugaccess,
   output logic              waitrequest,
   output logic [63:0]       readdata,
   output logic              readdatavalid,
   output logic              kernel_start,
   output logic [63:0]       kernel_arg0,
   output logic [63:0]       kernel_arg1,
   input  logic              kernel_done,
   output logic              kernel_irq
);

   state_t      state_q, state_d;
   logic        wait_q;
   logic        irq_en_q;
   logic [63:0] arg0_q, arg1_q, scratch_q;
   logic [63:0] cycles;
   logic [63:0] rd_mux;
   logic [63:0] status;
   logic [2:0]  word;
   logic        accept, wr_acc, rd_acc;
   logic        start_req, done_clr, enter_run;

   // Bits outside the decoded word index, plus the fixed-value sideband
   // inputs, carry no meaning for this slave.
   logic unused_inputs;
   assign unused_inputs = ^{burstcount, debugaccess, address[ADDR_W-1:6], address[2:0]};

   // Held high through reset and for the first cycle after release.
   assign waitrequest = wait_q | ~board_kernel_reset_reset_n;

   assign word   = address[5:3];
   assign accept = ~waitrequest & (read | write);
   assign wr_acc = accept & write;
   // A simultaneous read+write is handled as a write only.
   assign rd_acc = accept & read & ~write;

   assign start_req = wr_acc && (word == REG_CTRL)   && byteenable[0] && writedata[CTRL_START_BIT];
   assign done_clr  = wr_acc && (word == REG_STATUS) && byteenable[0] && writedata[STATUS_DONE_BIT];

   assign kernel_irq  = (state_q == DONE) & irq_en_q;
   assign kernel_arg0 = arg0_q;
   assign kernel_arg1 = arg1_q;

   always_comb begin
      status                  = '0;
      status[STATUS_BUSY_BIT] = (state_q == RUN);
      status[STATUS_DONE_BIT] = (state_q == DONE);
      status[STATUS_IRQ_BIT]  = kernel_irq;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_req)   state_d = RUN;
         RUN:     if (kernel_done) state_d = DONE;
         DONE: begin
            if (start_req)     state_d = RUN;
            else if (done_clr) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign enter_run = (state_q != RUN) && (state_d == RUN);

   always_comb begin
      rd_mux = '0;
      case (word)
         REG_ID:      rd_mux = CRA_ID;
         REG_CTRL:    rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
         REG_STATUS:  rd_mux = status;
         REG_ARG0:    rd_mux = arg0_q;
         REG_ARG1:    rd_mux = arg1_q;
         REG_CYCLES:  rd_mux = cycles;
         REG_SCRATCH: rd_mux = scratch_q;
         default:     rd_mux = '0;
      endcase
   end

`ifdef KERNEL_CRA_CYCLE_COUNTER_EN
   kernel_cra_cycle_counter u_cycle_counter (
      .clk    (kernel_clk),
      .rst_n  (board_kernel_reset_reset_n),
      .clear  (enter_run),
      .enable (state_q == RUN),
      .count  (cycles)
   );
`else
   assign cycles = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge kernel_clk) begin
      if (!board_kernel_reset_reset_n) begin
         state_q       <= IDLE;
         wait_q        <= 1'b1;
         irq_en_q      <= 1'b0;
         arg0_q        <= '0;
         arg1_q        <= '0;
         scratch_q     <= '0;
         kernel_start  <= 1'b0;
         readdatavalid <= 1'b0;
         readdata      <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= 1'b0;
         kernel_start  <= enter_run;
         readdatavalid <= rd_acc;
         // Status is captured from pre-edge state, so a read coinciding with
         // kernel_done still reports BUSY.
         if (rd_acc) readdata <= rd_mux;
         if (wr_acc) begin
            case (word)
               REG_CTRL:    if (byteenable[0]) irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
               REG_ARG0:    arg0_q    <= byte_merge(arg0_q, writedata, byteenable);
               REG_ARG1:    arg1_q    <= byte_merge(arg1_q, writedata, byteenable);
               REG_SCRATCH: scratch_q <= byte_merge(scratch_q, writedata, byteenable);
               default:     ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kernel_cra_responder.sv
// -----------------------------------------------------------------------------
// tb_kernel_cra_responder
// Self-checking bench for kernel_cra_responder: directed scenarios followed by
// random CRA traffic, compared every cycle against a register-map model.
// -----------------------------------------------------------------------------
module tb_kernel_cra_responder;

   localparam logic [63:0] ID_VALUE = 64'h0000_4B52_4E4C_0001;
`ifdef KERNEL_CRA_CYCLE_COUNTER_EN
   localparam logic [63:0] EXP_RUN10 = 64'd10;
`else
   localparam logic [63:0] EXP_RUN10 = 64'd0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] cra_address;
   logic        cra_read, cra_write;
   logic [63:0] cra_writedata;
   logic [7:0]  cra_byteenable;
   logic        k_done;
   logic        waitrequest, readdatavalid, kernel_start, kernel_irq;
   logic [63:0] readdata, kernel_arg0, kernel_arg1;

   always #5 clk = ~clk;

   kernel_cra_responder dut (
      .kernel_clk                 (clk),
      .board_kernel_reset_reset_n (rst_n),
      .address                    (cra_address),
      .read                       (cra_read),
      .write                      (cra_write),
      .writedata                  (cra_writedata),
      .byteenable                 (cra_byteenable),
      .burstcount                 (1'b1),
      .debugaccess                (1'b0),
      .waitrequest                (waitrequest),
      .readdata                   (readdata),
      .readdatavalid              (readdatavalid),
      .kernel_start               (kernel_start),
      .kernel_arg0                (kernel_arg0),
      .kernel_arg1                (kernel_arg1),
      .kernel_done                (k_done),
      .kernel_irq                 (kernel_irq)
   );

   int errors = 0;
   int checks = 0;
   int n_start = 0;

   always @(negedge clk) if (kernel_start === 1'b1) n_start++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_state = M_IDLE;
   logic        m_wait = 1'b1;
   logic        m_irq_en = 1'b0;
   logic [63:0] m_arg0 = '0, m_arg1 = '0, m_scratch = '0, m_cycles = '0;
   logic        exp_rdv = 1'b0, exp_start = 1'b0;
   logic [63:0] exp_rd = '0;

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] b);
      logic [63:0] r;
      r = o;
      for (int i = 0; i < 8; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [63:0] model_read(input logic [2:0] w);
      logic [63:0] v;
      v = '0;
      case (w)
         3'd0: v = ID_VALUE;
         3'd1: v[1] = m_irq_en;
         3'd2: begin
            v[0] = (m_state == M_RUN);
            v[1] = (m_state == M_DONE);
            v[2] = (m_state == M_DONE) && m_irq_en;
         end
         3'd3: v = m_arg0;
         3'd4: v = m_arg1;
`ifdef KERNEL_CRA_CYCLE_COUNTER_EN
         3'd5: v = m_cycles;
`endif
         3'd6: v = m_scratch;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Advance one clock, update the model from the inputs seen at that edge,
   // then compare every output shortly after the edge.
   task automatic tick();
      logic       acc, st, clr;
      logic [2:0] w;
      int         prev;
      @(posedge clk);
      w = cra_address[5:3];
      if (!rst_n) begin
         m_state = M_IDLE; m_wait = 1'b1; m_irq_en = 1'b0;
         m_arg0 = '0; m_arg1 = '0; m_scratch = '0; m_cycles = '0;
         exp_rdv = 1'b0; exp_rd = '0; exp_start = 1'b0;
      end else begin
         acc     = !m_wait && (cra_read || cra_write);
         exp_rdv = acc && cra_read && !cra_write;
         if (exp_rdv) exp_rd = model_read(w);
         st  = acc && cra_write && (w == 3'd1) && cra_byteenable[0] && cra_writedata[0];
         clr = acc && cra_write && (w == 3'd2) && cra_byteenable[0] && cra_writedata[1];
         if (acc && cra_write) begin
            if (w == 3'd1 && cra_byteenable[0]) m_irq_en = cra_writedata[1];
            if (w == 3'd3) m_arg0    = merge(m_arg0, cra_writedata, cra_byteenable);
            if (w == 3'd4) m_arg1    = merge(m_arg1, cra_writedata, cra_byteenable);
            if (w == 3'd6) m_scratch = merge(m_scratch, cra_writedata, cra_byteenable);
         end
         prev = m_state;
         if (m_state == M_RUN && m_cycles != '1) m_cycles = m_cycles + 1;
         if (m_state == M_IDLE && st) m_state = M_RUN;
         else if (m_state == M_RUN && k_done) m_state = M_DONE;
         else if (m_state == M_DONE && st) m_state = M_RUN;
         else if (m_state == M_DONE && clr) m_state = M_IDLE;
         if (prev != M_RUN && m_state == M_RUN) m_cycles = '0;
         exp_start = (prev != M_RUN) && (m_state == M_RUN);
         m_wait = 1'b0;
      end
      #1;
      check("readdatavalid", 64'(readdatavalid), 64'(exp_rdv));
      check("readdata", readdata, exp_rd);
      check("kernel_start", 64'(kernel_start), 64'(exp_start));
      check("kernel_irq", 64'(kernel_irq), 64'((m_state == M_DONE) && m_irq_en));
      check("kernel_arg0", kernel_arg0, m_arg0);
      check("kernel_arg1", kernel_arg1, m_arg1);
      check("waitrequest_post", 64'(waitrequest), 64'(!rst_n || m_wait));
   endtask

   task automatic cycle(input logic r, input logic w, input logic [2:0] word,
                        input logic [63:0] d, input logic [7:0] b,
                        input logic dn, input logic rs);
      cra_read       = r;
      cra_write      = w;
      cra_address    = {24'($urandom), word, 3'b000};
      cra_writedata  = d;
      cra_byteenable = b;
      k_done         = dn;
      rst_n          = rs;
      #1;
      check("waitrequest_mid", 64'(waitrequest), 64'(!rs || m_wait));
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd7, '0, '0, 1'b0, 1'b1);
   endtask

   task automatic wr_reg(input logic [2:0] word, input logic [63:0] d, input logic [7:0] b);
      cycle(1'b0, 1'b1, word, d, b, 1'b0, 1'b1);
   endtask

   task automatic rd_reg(input logic [2:0] word);
      cycle(1'b1, 1'b0, word, '0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      int base;
      cra_read = 1'b0; cra_write = 1'b0; cra_address = '0; cra_writedata = '0;
      cra_byteenable = '0; k_done = 1'b0; rst_n = 1'b0;

      // Reset, one wait cycle, then ID read.
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
      idle(1);
      check("wait_low_cycle2", 64'(waitrequest), 64'd0);
      rd_reg(3'd0);
      check("id_rdv", 64'(readdatavalid), 64'd1);
      check("id_value", readdata, 64'h0000_4B52_4E4C_0001);

      // Partial byte-enable write.
      wr_reg(3'd3, 64'hDEAD_BEEF_0123_4567, 8'h0F);
      rd_reg(3'd3);
      check("arg0_be", readdata, 64'h0000_0000_0123_4567);

      // Launch, 10 RUN cycles, completion.
      base = n_start;
      wr_reg(3'd1, 64'h3, 8'hFF);
      idle(9);
      cycle(1'b0, 1'b0, 3'd7, '0, '0, 1'b1, 1'b1);
      rd_reg(3'd2);
      check("status_done", readdata, 64'h6);
      check("irq_done", 64'(kernel_irq), 64'd1);
      rd_reg(3'd5);
      check("cycles_10", readdata, EXP_RUN10);
      check("start_once", 64'(n_start - base), 64'd1);

      // Relaunch from DONE, START ignored while busy, then W1C.
      base = n_start;
      wr_reg(3'd1, 64'h3, 8'hFF);
      wr_reg(3'd1, 64'h3, 8'hFF);
      idle(2);
      check("no_second_start", 64'(n_start - base), 64'd1);
      cycle(1'b0, 1'b0, 3'd7, '0, '0, 1'b1, 1'b1);
      wr_reg(3'd2, 64'h2, 8'hFF);
      rd_reg(3'd2);
      check("status_cleared", readdata, 64'h0);
      check("irq_cleared", 64'(kernel_irq), 64'd0);

      // Read+write together is a write only.
      cycle(1'b1, 1'b1, 3'd6, 64'h55, 8'hFF, 1'b0, 1'b1);
      check("rw_no_rdv", 64'(readdatavalid), 64'd0);
      rd_reg(3'd6);
      check("scratch", readdata, 64'h55);

      // kernel_done coinciding with a STATUS read.
      wr_reg(3'd1, 64'h3, 8'hFF);
      cycle(1'b1, 1'b0, 3'd2, '0, '0, 1'b1, 1'b1);
      check("coincide_busy", readdata, 64'h1);
      rd_reg(3'd2);
      check("coincide_done", readdata, 64'h6);

      // Reset mid-RUN with a read presented.
      wr_reg(3'd1, 64'h1, 8'hFF);
      idle(2);
      base = n_start;
      cycle(1'b1, 1'b0, 3'd2, '0, '0, 1'b0, 1'b0);
      check("rst_no_rdv", 64'(readdatavalid), 64'd0);
      idle(2);
      rd_reg(3'd2);
      check("status_after_rst", readdata, 64'h0);
      check("rst_no_start", 64'(n_start - base), 64'd0);

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 3'($urandom),
               {$urandom(), $urandom()}, 8'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
